// File: rtl/dma_path_responder.sv
// dma_path_responder: target-side endpoint of the load/store DMA path.
// The block grants one requester, then decodes a 128-bit command header from
// the write stream. After that it either forwards write beats to the host
// memory port or returns host read beats on the read stream. Each returned
// read beat is tagged with an incrementing 12-bit local address.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   dma_req / dma_resp        request in, one-cycle grant pulse out
//   dma_write_*               header / write-data stream from the requester
//   dma_read_*                140-bit read stream {local_addr, data} back to requester
//   host_cmd_*                host command {rwn, addr, len} with valid/ready
//   host_wr_*                 host write beats with valid/ready
//   host_rd_*                 host read beats with valid/ready
//   busy                      high whenever the FSM is not idle
//   err_opcode                one-cycle pulse on an unknown header opcode
module dma_path_responder (
  input  logic         clk,
  input  logic         rst,
  input  logic         dma_req,
  output logic         dma_resp,
  input  logic         dma_write_valid,
  input  logic [127:0] dma_write_data,
  output logic         dma_write_ready,
  output logic         dma_read_valid,
  output logic [139:0] dma_read_data,
  input  logic         dma_read_ready,
  output logic         host_cmd_valid,
  input  logic         host_cmd_ready,
  output logic         host_cmd_rwn,
  output logic [39:0]  host_cmd_addr,
  output logic [15:0]  host_cmd_len,
  output logic         host_wr_valid,
  input  logic         host_wr_ready,
  output logic [127:0] host_wr_data,
  input  logic         host_rd_valid,
  output logic         host_rd_ready,
  input  logic [127:0] host_rd_data,
  output logic         busy,
  output logic         err_opcode
);

  localparam int unsigned DATA_W  = 128;
  localparam int unsigned LADDR_W = 12;
  localparam int unsigned HADDR_W = 40;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned OP_W    = 8;

  localparam logic [OP_W-1:0] OP_WRITE = 8'h03;
  localparam logic [OP_W-1:0] OP_READ  = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_HDR   = 3'd2,
    S_CMD   = 3'd3,
    S_WDATA = 3'd4,
    S_RDATA = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [OP_W-1:0]    opcode_q, opcode_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [HADDR_W-1:0] haddr_q, haddr_d;
  logic [LADDR_W-1:0] cur_local_q, cur_local_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;

  // Header field decode straight off the write stream
  logic [LADDR_W-1:0] hdr_laddr;
  logic [HADDR_W-1:0] hdr_haddr;
  logic [LEN_W-1:0]   hdr_len;
  logic [OP_W-1:0]    hdr_op;
  logic               hdr_op_ok;

  assign hdr_laddr = dma_write_data[11:0];
  assign hdr_haddr = dma_write_data[55:16];
  assign hdr_len   = dma_write_data[71:56];
  assign hdr_op    = dma_write_data[79:72];
  assign hdr_op_ok = (hdr_op == OP_WRITE) || (hdr_op == OP_READ);

  // Beat handshakes on the pass-through paths
  logic wr_hs, rd_hs, last_beat;

  assign wr_hs     = (state_q == S_WDATA) && dma_write_valid && host_wr_ready;
  assign rd_hs     = (state_q == S_RDATA) && host_rd_valid && dma_read_ready;
  assign last_beat = (LEN_W'(beat_cnt_q + 16'd1) == len_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (dma_req) state_d = S_GRANT;
      S_GRANT: state_d = S_HDR;
      S_HDR: begin
        if (dma_write_valid) begin
          // Zero-length or unknown-opcode headers skip the host side entirely
          if (hdr_op_ok && (hdr_len != '0)) state_d = S_CMD;
          else                               state_d = S_DONE;
        end
      end
      S_CMD: begin
        if (host_cmd_ready) state_d = (opcode_q == OP_WRITE) ? S_WDATA : S_RDATA;
      end
      S_WDATA: if (wr_hs && last_beat) state_d = S_DONE;
      S_RDATA: if (rd_hs && last_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; data paths are zero-latency pass-throughs gated by state
  always_comb begin
    dma_resp        = 1'b0;
    dma_write_ready = 1'b0;
    dma_read_valid  = 1'b0;
    dma_read_data   = '0;
    host_cmd_valid  = 1'b0;
    host_wr_valid   = 1'b0;
    host_wr_data    = '0;
    host_rd_ready   = 1'b0;
    err_opcode      = 1'b0;
    busy            = (state_q != S_IDLE);
    host_cmd_rwn    = (opcode_q == OP_READ);
    host_cmd_addr   = haddr_q;
    host_cmd_len    = len_q;
    case (state_q)
      S_GRANT: dma_resp = 1'b1;
      S_HDR: begin
        dma_write_ready = 1'b1;
        err_opcode      = dma_write_valid && !hdr_op_ok;
      end
      S_CMD: host_cmd_valid = 1'b1;
      S_WDATA: begin
        host_wr_valid   = dma_write_valid;
        host_wr_data    = dma_write_data;
        dma_write_ready = host_wr_ready;
      end
      S_RDATA: begin
        dma_read_valid = host_rd_valid;
        dma_read_data  = {cur_local_q, host_rd_data};
        host_rd_ready  = dma_read_ready;
      end
      default: ;
    endcase
  end

  // Header capture, beat counting and local-address tagging
  always_comb begin
    opcode_d    = opcode_q;
    len_d       = len_q;
    haddr_d     = haddr_q;
    cur_local_d = cur_local_q;
    beat_cnt_d  = beat_cnt_q;
    if ((state_q == S_HDR) && dma_write_valid) begin
      opcode_d    = hdr_op;
      len_d       = hdr_len;
      haddr_d     = hdr_haddr;
      cur_local_d = hdr_laddr;
    end
    if (wr_hs || rd_hs) beat_cnt_d = LEN_W'(beat_cnt_q + 16'd1);
    // 12-bit add wraps 0xFFF -> 0x000 naturally
    if (rd_hs) cur_local_d = LADDR_W'(cur_local_q + 12'd1);
    if (state_q == S_DONE) beat_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q    <= '0;
      len_q       <= '0;
      haddr_q     <= '0;
      cur_local_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      opcode_q    <= opcode_d;
      len_q       <= len_d;
      haddr_q     <= haddr_d;
      cur_local_q <= cur_local_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // DATA_W documents the payload width carried on both streams
  logic unused_w;
  assign unused_w = (DATA_W == 128);

endmodule

// File: tb/tb_dma_path_responder.sv
// Testbench for dma_path_responder: per-cycle vector table plus a
// hand-written reset-abort / bounded-wait read sequence.
module tb_dma_path_responder;

  logic         clk;
  logic         rst;
  logic         dma_req;
  logic         dma_resp;
  logic         dma_write_valid;
  logic [127:0] dma_write_data;
  logic         dma_write_ready;
  logic         dma_read_valid;
  logic [139:0] dma_read_data;
  logic         dma_read_ready;
  logic         host_cmd_valid;
  logic         host_cmd_ready;
  logic         host_cmd_rwn;
  logic [39:0]  host_cmd_addr;
  logic [15:0]  host_cmd_len;
  logic         host_wr_valid;
  logic         host_wr_ready;
  logic [127:0] host_wr_data;
  logic         host_rd_valid;
  logic         host_rd_ready;
  logic [127:0] host_rd_data;
  logic         busy;
  logic         err_opcode;

  dma_path_responder dut (
    .clk             (clk),
    .rst             (rst),
    .dma_req         (dma_req),
    .dma_resp        (dma_resp),
    .dma_write_valid (dma_write_valid),
    .dma_write_data  (dma_write_data),
    .dma_write_ready (dma_write_ready),
    .dma_read_valid  (dma_read_valid),
    .dma_read_data   (dma_read_data),
    .dma_read_ready  (dma_read_ready),
    .host_cmd_valid  (host_cmd_valid),
    .host_cmd_ready  (host_cmd_ready),
    .host_cmd_rwn    (host_cmd_rwn),
    .host_cmd_addr   (host_cmd_addr),
    .host_cmd_len    (host_cmd_len),
    .host_wr_valid   (host_wr_valid),
    .host_wr_ready   (host_wr_ready),
    .host_wr_data    (host_wr_data),
    .host_rd_valid   (host_rd_valid),
    .host_rd_ready   (host_rd_ready),
    .host_rd_data    (host_rd_data),
    .busy            (busy),
    .err_opcode      (err_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  typedef struct packed {
    logic         rst;
    logic         req;
    logic         wv;
    logic [127:0] wd;
    logic         rr;
    logic         cr;
    logic         wr;
    logic         rv;
    logic [127:0] rd;
  } in_t;

  typedef struct packed {
    logic         resp;
    logic         wready;
    logic         rvalid;
    logic [139:0] rdata;
    logic         cmd_valid;
    logic         rwn;
    logic [39:0]  addr;
    logic [15:0]  len;
    logic         wr_valid;
    logic [127:0] wr_data;
    logic         rd_ready;
    logic         busy;
    logic         err;
  } out_t;

  typedef struct {
    logic raw;
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic in_t mk_in(input logic r, input logic rq, input logic wv,
                                input logic [127:0] wd, input logic rr, input logic cr,
                                input logic wr, input logic rv, input logic [127:0] rd);
    in_t v;
    v.rst = r; v.req = rq; v.wv = wv; v.wd = wd; v.rr = rr;
    v.cr = cr; v.wr = wr; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  function automatic out_t mk_out(input logic resp, input logic wready, input logic rvalid,
                                  input logic [139:0] rdata, input logic cv, input logic rwn,
                                  input logic [39:0] addr, input logic [15:0] len,
                                  input logic wv, input logic [127:0] wdat,
                                  input logic rdy, input logic bsy, input logic err);
    out_t v;
    v.resp = resp; v.wready = wready; v.rvalid = rvalid; v.rdata = rdata;
    v.cmd_valid = cv; v.rwn = rwn; v.addr = addr; v.len = len;
    v.wr_valid = wv; v.wr_data = wdat; v.rd_ready = rdy; v.busy = bsy; v.err = err;
    return v;
  endfunction

  function automatic logic [127:0] hdr(input logic [7:0] op, input logic [15:0] len,
                                       input logic [39:0] ha, input logic [11:0] la);
    return {48'h0, op, len, ha, 4'h0, la};
  endfunction

  // Shorthand input patterns
  function automatic in_t i_req();
    return mk_in(N, Y, N, '0, N, N, N, N, '0);
  endfunction
  function automatic in_t i_hdr(input logic [127:0] h);
    return mk_in(N, N, Y, h, N, N, N, N, '0);
  endfunction
  function automatic in_t i_cmd(input logic cr);
    return mk_in(N, N, N, '0, N, cr, N, N, '0);
  endfunction
  function automatic in_t i_wr(input logic wv, input logic [127:0] wd, input logic wr);
    return mk_in(N, N, wv, wd, N, N, wr, N, '0);
  endfunction
  function automatic in_t i_rd(input logic rr, input logic rv, input logic [127:0] rd);
    return mk_in(N, N, N, '0, rr, N, N, rv, rd);
  endfunction

  // Shorthand expected patterns
  function automatic out_t o_busy();
    return mk_out(N, N, N, '0, N, N, '0, '0, N, '0, N, Y, N);
  endfunction
  function automatic out_t o_grant();
    return mk_out(Y, N, N, '0, N, N, '0, '0, N, '0, N, Y, N);
  endfunction
  function automatic out_t o_hdr(input logic err);
    return mk_out(N, Y, N, '0, N, N, '0, '0, N, '0, N, Y, err);
  endfunction
  function automatic out_t o_cmd(input logic rwn, input logic [39:0] a, input logic [15:0] l);
    return mk_out(N, N, N, '0, Y, rwn, a, l, N, '0, N, Y, N);
  endfunction
  function automatic out_t o_wr(input logic wrdy, input logic wv, input logic [127:0] d);
    return mk_out(N, wrdy, N, '0, N, N, '0, '0, wv, d, N, Y, N);
  endfunction
  function automatic out_t o_rd(input logic rv, input logic [139:0] d, input logic rdy);
    return mk_out(N, N, rv, d, N, N, '0, '0, N, '0, rdy, Y, N);
  endfunction

  function automatic void add(input logic raw, input in_t i, input out_t o);
    vec_t v;
    v.raw = raw; v.i = i; v.o = o;
    vecs.push_back(v);
  endfunction

  function automatic out_t sample();
    out_t a;
    a.resp = dma_resp; a.wready = dma_write_ready; a.rvalid = dma_read_valid;
    a.rdata = dma_read_data; a.cmd_valid = host_cmd_valid; a.rwn = host_cmd_rwn;
    a.addr = host_cmd_addr; a.len = host_cmd_len; a.wr_valid = host_wr_valid;
    a.wr_data = host_wr_data; a.rd_ready = host_rd_ready; a.busy = busy;
    a.err = err_opcode;
    return a;
  endfunction

  // Payload/command fields are don't-care while their valid is low
  function automatic out_t norm(input out_t o);
    out_t r = o;
    if (!r.cmd_valid) begin r.rwn = 1'b0; r.addr = '0; r.len = '0; end
    if (!r.rvalid)   r.rdata = '0;
    if (!r.wr_valid) r.wr_data = '0;
    return r;
  endfunction

  task automatic drive(input in_t i);
    rst             = i.rst;
    dma_req         = i.req;
    dma_write_valid = i.wv;
    dma_write_data  = i.wd;
    dma_read_ready  = i.rr;
    host_cmd_ready  = i.cr;
    host_wr_ready   = i.wr;
    host_rd_valid   = i.rv;
    host_rd_data    = i.rd;
  endtask

  // One cycle: drive at negedge, compare 1 time unit later
  task automatic step(input string name, input logic raw, input in_t i, input out_t e);
    out_t a;
    out_t ex;
    @(negedge clk);
    drive(i);
    #1;
    a  = sample();
    ex = e;
    if (!raw) begin
      a  = norm(a);
      ex = norm(ex);
    end
    checks++;
    if (a !== ex) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, a, ex);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [127:0] hw, hb, hc, hd, he, hf, hr;
  logic [127:0] d1, d2, d3, e1, e2, e3;

  initial begin
    logic seen;

    drive(mk_in(Y, N, N, '0, N, N, N, N, '0));

    hw = hdr(8'h03, 16'd3, 40'h12_3456_7890, 12'h010)
         | {48'hDEAD_BEEF_CAFE, 64'h0, 4'hF, 12'h000};
    hb = hdr(8'h01, 16'd4, 40'h00_0000_1000, 12'hFFE);
    hc = hdr(8'h01, 16'd2, 40'h00_0000_0055, 12'h100);
    hd = hdr(8'h07, 16'd1, 40'h00_0000_0042, 12'h000);
    he = hdr(8'h03, 16'd0, 40'h00_0000_0043, 12'h000);
    hf = hdr(8'h03, 16'd5, 40'h00_0000_0077, 12'h000);
    hr = hdr(8'h01, 16'd1, 40'h00_0000_0099, 12'h7AB);
    d1 = {4{32'hA5A5_0001}};
    d2 = {4{32'h5A5A_0002}};
    d3 = {4{32'hC3C3_0003}};
    e1 = {4{32'hE000_0001}};
    e2 = {4{32'hE000_0002}};
    e3 = {4{32'hE000_0003}};

    // Reset with noisy inputs: every output must be 0
    add(Y, mk_in(Y, Y, Y, d1, Y, Y, Y, Y, 128'hA), '0);
    add(Y, mk_in(N, N, N, '0, N, N, N, N, '0), '0);

    // Write len=3, with a ready stall and a valid stall
    add(N, i_req(), '0);
    add(N, i_req(), o_grant());
    add(N, i_hdr(hw), o_hdr(N));
    add(N, i_cmd(Y), o_cmd(N, 40'h12_3456_7890, 16'd3));
    add(N, i_wr(Y, d1, Y), o_wr(Y, Y, d1));
    add(N, i_wr(Y, d2, N), o_wr(N, Y, d2));
    add(N, i_wr(Y, d2, Y), o_wr(Y, Y, d2));
    add(N, i_wr(N, d3, Y), o_wr(Y, N, '0));
    add(N, i_wr(Y, d3, Y), o_wr(Y, Y, d3));
    add(N, i_wr(Y, d3, Y), o_busy());
    add(N, '0, '0);

    // Read len=4 from local 0xFFE, one cmd_ready stall, tag wraps
    add(N, i_req(), '0);
    add(N, i_req(), o_grant());
    add(N, i_hdr(hb), o_hdr(N));
    add(N, i_cmd(N), o_cmd(Y, 40'h00_0000_1000, 16'd4));
    add(N, i_cmd(Y), o_cmd(Y, 40'h00_0000_1000, 16'd4));
    add(N, i_rd(Y, Y, 128'hA), o_rd(Y, {12'hFFE, 128'hA}, Y));
    add(N, i_rd(Y, Y, 128'hB), o_rd(Y, {12'hFFF, 128'hB}, Y));
    add(N, i_rd(Y, Y, 128'hC), o_rd(Y, {12'h000, 128'hC}, Y));
    add(N, i_rd(Y, Y, 128'hD), o_rd(Y, {12'h001, 128'hD}, Y));
    add(N, i_rd(Y, N, '0), o_busy());
    add(N, '0, '0);

    // Read len=2 with dma_read_ready 1,0,0,1 and host_rd_valid held
    add(N, i_req(), '0);
    add(N, i_req(), o_grant());
    add(N, i_hdr(hc), o_hdr(N));
    add(N, i_cmd(Y), o_cmd(Y, 40'h00_0000_0055, 16'd2));
    add(N, i_rd(Y, Y, 128'h11), o_rd(Y, {12'h100, 128'h11}, Y));
    add(N, i_rd(N, Y, 128'h22), o_rd(Y, {12'h101, 128'h22}, N));
    add(N, i_rd(N, Y, 128'h22), o_rd(Y, {12'h101, 128'h22}, N));
    add(N, i_rd(Y, Y, 128'h22), o_rd(Y, {12'h101, 128'h22}, Y));
    add(N, i_rd(Y, Y, 128'h33), o_busy());
    add(N, i_rd(Y, Y, 128'h33), '0);

    // Bad opcode 0x07, req held through DONE, then a write len=0
    add(N, i_req(), '0);
    add(N, i_req(), o_grant());
    add(N, i_hdr(hd), o_hdr(Y));
    add(N, i_req(), o_busy());
    add(N, i_req(), '0);
    add(N, i_req(), o_grant());
    add(N, i_hdr(he), o_hdr(N));
    add(N, '0, o_busy());
    add(N, '0, '0);

    foreach (vecs[k]) begin
      step($sformatf("vec%0d", k), vecs[k].raw, vecs[k].i, vecs[k].o);
    end

    // Reset during WDATA after 2 of 5 beats aborts the transfer immediately
    step("rst_req",   N, i_req(), '0);
    step("rst_grant", N, i_req(), o_grant());
    step("rst_hdr",   N, i_hdr(hf), o_hdr(N));
    step("rst_cmd",   N, i_cmd(Y), o_cmd(N, 40'h00_0000_0077, 16'd5));
    step("rst_beat1", N, i_wr(Y, e1, Y), o_wr(Y, Y, e1));
    step("rst_beat2", N, i_wr(Y, e2, Y), o_wr(Y, Y, e2));
    step("rst_assert", Y, mk_in(Y, N, Y, e3, N, N, Y, N, '0), '0);
    step("rst_after1", Y, i_wr(Y, e3, Y), '0);
    step("rst_after2", Y, i_wr(Y, e3, Y), '0);

    // Following read len=1, host data arrives after a wait cycle
    step("rd1_req",   N, i_req(), '0);
    step("rd1_grant", N, i_req(), o_grant());
    step("rd1_hdr",   N, i_hdr(hr), o_hdr(N));
    step("rd1_cmd",   N, i_cmd(Y), o_cmd(Y, 40'h00_0000_0099, 16'd1));
    step("rd1_wait",  N, i_rd(Y, N, '0), o_rd(N, '0, Y));

    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(i_rd(Y, Y, 128'hBEEF));
      #1;
      if (dma_read_valid) begin
        seen = 1'b1;
        checks++;
        if (dma_read_data !== {12'h7AB, 128'hBEEF}) begin
          errors++;
          $display("FAIL rd1_data got=%h exp=%h", dma_read_data, {12'h7AB, 128'hBEEF});
        end
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rd1_timeout got=no read beat exp=read beat within 4 cycles");
    end

    step("rd1_done", N, i_rd(Y, N, '0), o_busy());
    step("rd1_idle", N, i_rd(Y, N, '0), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
